// File: rtl/stash_pkt_buffer.sv
// stash_pkt_buffer
// Store-and-forward packet buffer for the cache-miss (stash) path. Whole packets
// are written into a beat RAM and only become visible to the read side once
// their last beat has landed. A packet that does not fit is rolled back and
// dropped in its entirety, so upstream never has to stall mid-packet.
// Optional build macro: STASH_STATS_EN adds the pkt_cnt / drop_cnt counters.
//
// Write FSM states:
//   state    | meaning
//   ST_IDLE  | between packets, next valid beat starts a new packet
//   ST_PKT   | inside a packet that is still being stored
//   ST_DROP  | packet overflowed, discarding beats until tlast
module stash_pkt_buffer #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int DEPTH_BITS           = 9,
    parameter int MAX_PKT_BEATS        = 48
) (
    input  logic                                axis_aclk,
    input  logic                                axis_resetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    input  logic                                s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                                m_axis_tlast,
    output logic                                m_axis_tvalid,
`ifdef STASH_STATS_EN
    output logic [31:0]                         pkt_cnt,
    output logic [31:0]                         drop_cnt,
`endif
    input  logic                                m_axis_tready
);

    localparam int DW      = C_S_AXIS_DATA_WIDTH;
    localparam int KW      = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW      = C_S_AXIS_TUSER_WIDTH;
    localparam int ENTRY_W = DW + KW + UW + 1;
    localparam int DEPTH   = 1 << DEPTH_BITS;
    localparam int PTR_W   = DEPTH_BITS + 1;

    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] MAX_P   = PTR_W'(MAX_PKT_BEATS);
    localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_DROP = 2'd2
    } wr_state_t;

    wr_state_t          wr_state;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   commit_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   used;
    logic [PTR_W-1:0]   free;
    logic               free_zero;
    logic               wr_en;
    logic               rst_done;

    logic [ENTRY_W-1:0] mem [DEPTH];

    logic               readable;
    logic               out_ready;
    logic               s1_ready;
    logic               rd_en;
    logic               s1_valid;
    logic [ENTRY_W-1:0] s1_data;

    // Occupancy counts beats already pulled into the read pipeline as freed,
    // which is safe because those RAM slots are never read again.
    assign used      = wr_ptr - rd_ptr;
    assign free      = DEPTH_P - used;
    assign free_zero = (free == '0);
    assign wr_en     = s_axis_tvalid && (wr_state != ST_DROP) && !free_zero;

    assign s_axis_tready = rst_done && (free >= MAX_P);

    // Holds tready low until the first clock after reset release.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    // Write FSM: store beats, commit on tlast, roll back and drop on overflow.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            wr_state   <= ST_IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
        end else if (s_axis_tvalid) begin
            case (wr_state)
                ST_DROP: begin
                    if (s_axis_tlast) begin
                        wr_state <= ST_IDLE;
                    end
                end
                default: begin
                    if (free_zero) begin
                        wr_ptr   <= commit_ptr;
                        wr_state <= s_axis_tlast ? ST_IDLE : ST_DROP;
                    end else begin
                        wr_ptr <= wr_ptr + ONE_P;
                        if (s_axis_tlast) begin
                            commit_ptr <= wr_ptr + ONE_P;
                            wr_state   <= ST_IDLE;
                        end else begin
                            wr_state <= ST_PKT;
                        end
                    end
                end
            endcase
        end
    end

    // Beat RAM write port.
    always_ff @(posedge axis_aclk) begin
        if (wr_en) begin
            mem[wr_ptr[DEPTH_BITS-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
        end
    end

    // Two-stage read pipeline: registered RAM read (s1) then the output register.
    // Only committed beats are readable, so a packet in flight is never exposed.
    assign readable  = (rd_ptr != commit_ptr);
    assign out_ready = !m_axis_tvalid || m_axis_tready;
    assign s1_ready  = !s1_valid || out_ready;
    assign rd_en     = readable && s1_ready;

    // RAM read port; contents are qualified by s1_valid.
    always_ff @(posedge axis_aclk) begin
        if (rd_en) begin
            s1_data <= mem[rd_ptr[DEPTH_BITS-1:0]];
        end
    end

    // Read pointer and stage-1 occupancy.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            rd_ptr   <= '0;
            s1_valid <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_ptr <= rd_ptr + ONE_P;
            end
            if (s1_ready) begin
                s1_valid <= rd_en;
            end
        end
    end

    // Output register: holds while stalled, zeroes its payload when it empties.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (out_ready) begin
            if (s1_valid) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s1_data[ENTRY_W-1 -: DW];
                m_axis_tkeep  <= s1_data[UW+KW:UW+1];
                m_axis_tuser  <= s1_data[UW:1];
                m_axis_tlast  <= s1_data[0];
            end else begin
                m_axis_tvalid <= 1'b0;
                m_axis_tdata  <= '0;
                m_axis_tkeep  <= '0;
                m_axis_tuser  <= '0;
                m_axis_tlast  <= 1'b0;
            end
        end
    end

`ifdef STASH_STATS_EN
    logic commit_evt;
    logic drop_evt;

    assign commit_evt = wr_en && s_axis_tlast;
    assign drop_evt   = s_axis_tvalid && (wr_state != ST_DROP) && free_zero;

    // Saturating packet statistics; a drop is counted on the overflowing beat only.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (commit_evt && (pkt_cnt != 32'hFFFF_FFFF)) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
            if (drop_evt && (drop_cnt != 32'hFFFF_FFFF)) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stash_pkt_buffer.sv
// Testbench for stash_pkt_buffer (small 64-beat configuration).
// Expected output is a queue of beats built from the packets the bench sends:
// every packet that should survive is appended in order, dropped ones are not.
`timescale 1ns/1ps
module tb_stash_pkt_buffer;
    localparam int DW   = 256;
    localparam int KW   = 32;
    localparam int UW   = 128;
    localparam int DB   = 6;
    localparam int MAXB = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic [UW-1:0] s_tuser;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [UW-1:0] m_tuser;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready;
`ifdef STASH_STATS_EN
    logic [31:0]   pkt_cnt;
    logic [31:0]   drop_cnt;
`endif

    stash_pkt_buffer #(
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_TUSER_WIDTH (UW),
        .DEPTH_BITS           (DB),
        .MAX_PKT_BEATS        (MAXB)
    ) dut (
        .axis_aclk     (clk),
        .axis_resetn   (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tuser  (m_tuser),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
`ifdef STASH_STATS_EN
        .pkt_cnt       (pkt_cnt),
        .drop_cnt      (drop_cnt),
`endif
        .m_axis_tready (m_tready)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    typedef struct {
        int            len;
        logic [KW-1:0] keep;
        int            exp_lat;
        int            exp_beats;
    } vec_t;

    beat_t exp_q[$];
    int    checks    = 0;
    int    failures  = 0;
    int    beats_out = 0;
    bit    rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic beat_t rand_beat(input logic last, input logic [KW-1:0] keep);
        beat_t b;
        b.data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        b.user = {$urandom, $urandom, $urandom, $urandom};
        b.keep = keep;
        b.last = last;
        return b;
    endfunction

    task automatic drive_beat(input beat_t b);
        s_tvalid = 1'b1;
        s_tdata  = b.data;
        s_tkeep  = b.keep;
        s_tuser  = b.user;
        s_tlast  = b.last;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_pkt(input int len, input logic [KW-1:0] last_keep, input bit survives, input bit bubbles);
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b = rand_beat(i == len - 1, (i == len - 1) ? last_keep : {KW{1'b1}});
            if (survives) exp_q.push_back(b);
            if (bubbles && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            drive_beat(b);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({name, "_drain_remaining"}, exp_q.size(), 0);
    endtask

    // Downstream backpressure, randomised when enabled.
    always @(posedge clk) begin
        #1;
        if (rand_ready) m_tready = 1'($urandom_range(0, 1));
    end

    // Output monitor: handshakes are judged at the falling edge before the capturing edge.
    beat_t held;
    bit    hold_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== held.data || m_tkeep !== held.keep ||
                    m_tuser !== held.user || m_tlast !== held.last) begin
                    failures++;
                    $display("FAIL hold_stable actual valid=%b data=%h required valid=1 data=%h",
                             m_tvalid, m_tdata, held.data);
                end
            end
            if (m_tvalid && m_tready) begin
                beat_t e;
                checks++;
                beats_out++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat actual data=%h last=%b required no beat", m_tdata, m_tlast);
                end else begin
                    e = exp_q.pop_front();
                    if (m_tdata !== e.data || m_tkeep !== e.keep || m_tuser !== e.user || m_tlast !== e.last) begin
                        failures++;
                        $display("FAIL out_beat actual data=%h keep=%h user=%h last=%b required data=%h keep=%h user=%h last=%b",
                                 m_tdata, m_tkeep, m_tuser, m_tlast, e.data, e.keep, e.user, e.last);
                    end
                end
            end
            hold_prev  = m_tvalid && !m_tready;
            held.data  = m_tdata;
            held.keep  = m_tkeep;
            held.user  = m_tuser;
            held.last  = m_tlast;
        end
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    vec_t vecs[4];
    int   base;
    int   lat;
    int   n;
    int   total_beats;
    int   plen;
    int   committed;

    initial begin
        vecs[0] = '{3, 32'hFFFF_FFFF, 2, 3};
        vecs[1] = '{1, 32'h0000_FFFF, 2, 1};
        vecs[2] = '{2, 32'h0000_000F, 2, 2};
        vecs[3] = '{5, 32'h00FF_FFFF, 2, 5};

        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0; s_tuser = '0;
        m_tready = 1'b1;
        rst_n    = 1'b0;
        committed = 0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_m_tvalid", m_tvalid, 0);
        check("reset_m_tdata_lo", m_tdata[63:0], 0);
        check("reset_s_tready", s_tready, 0);
`ifdef STASH_STATS_EN
        check("reset_pkt_cnt", pkt_cnt, 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("tready_before_first_edge", s_tready, 0);
        @(posedge clk);
        #1;
        check("tready_after_release", s_tready, 1);

        // Table of single packets with an open sink
        for (int v = 0; v < 4; v++) begin
            base = beats_out;
            lat  = 0;
            send_pkt(vecs[v].len, vecs[v].keep, 1'b1, 1'b0);
            @(negedge clk);
            while (!m_tvalid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            check("vec_latency", lat, vecs[v].exp_lat);
            wait_drain("vec", 50);
            check("vec_beats", beats_out - base, vecs[v].exp_beats);
            committed++;
        end
`ifdef STASH_STATS_EN
        check("table_pkt_cnt", pkt_cnt, committed);
`endif

        // Ten packets held back by a stalled sink, then released with random backpressure
        base = beats_out;
        m_tready = 1'b0;
        for (int p = 0; p < 10; p++) send_pkt(4, {KW{1'b1}}, 1'b1, 1'b0);
        committed += 10;
        repeat (5) @(posedge clk);
        #1;
        check("stall_no_output", beats_out - base, 0);
        check("stall_tvalid", m_tvalid, 1);
        rand_ready = 1'b1;
        wait_drain("stall", 600);
        rand_ready = 1'b0;
        m_tready = 1'b1;
        check("stall_beats", beats_out - base, 40);

        // Overflow: 64 beats fill RAM plus the two-deep read pipeline leaves 2 free,
        // so the 8-beat packet overflows on its third beat and must vanish.
        base = beats_out;
        #1;
        m_tready = 1'b0;
        for (int p = 0; p < 16; p++) send_pkt(4, {KW{1'b1}}, 1'b1, 1'b0);
        committed += 16;
        check("full_s_tready", s_tready, 0);
        send_pkt(8, {KW{1'b1}}, 1'b0, 1'b0);
`ifdef STASH_STATS_EN
        check("overflow_drop_cnt", drop_cnt, 1);
        check("overflow_pkt_cnt", pkt_cnt, committed);
`endif
        m_tready = 1'b1;
        wait_drain("overflow", 300);
        check("overflow_beats", beats_out - base, 64);
        check("drained_s_tready", s_tready, 1);
        base = beats_out;
        send_pkt(3, 32'h0000_00FF, 1'b1, 1'b0);
        committed++;
        wait_drain("post_overflow", 50);
        check("post_overflow_beats", beats_out - base, 3);

        // Reset on beat 2 of a 5-beat packet while a committed beat is stalled at the output
        m_tready = 1'b0;
        send_pkt(1, {KW{1'b1}}, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_tvalid", m_tvalid, 1);
        drive_beat(rand_beat(1'b0, {KW{1'b1}}));
        s_tvalid = 1'b1;
        s_tdata  = {8{32'hDEAD_BEEF}};
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear_tvalid", m_tvalid, 0);
        check("reset_mid_s_tready", s_tready, 0);
        s_tvalid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        base = beats_out;
        send_pkt(2, {KW{1'b1}}, 1'b1, 1'b0);
        wait_drain("post_reset", 50);
        check("post_reset_beats", beats_out - base, 2);
        committed = 1;
`ifdef STASH_STATS_EN
        check("post_reset_pkt_cnt", pkt_cnt, 1);
        check("post_reset_drop_cnt", drop_cnt, 0);
`endif

        // Random traffic honouring s_axis_tready at packet starts, random sink
        base = beats_out;
        total_beats = 0;
        rand_ready = 1'b1;
        for (int p = 0; p < 2000; p++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            n = 0;
            while (!s_tready && n < 1000) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (n >= 1000) begin
                checks++;
                failures++;
                $display("FAIL random_tready_wait actual=0 required=1");
                break;
            end
            plen = $urandom_range(1, 8);
            send_pkt(plen, $urandom, 1'b1, 1'b1);
            total_beats += plen;
            committed++;
        end
        wait_drain("random", 5000);
        rand_ready = 1'b0;
        m_tready = 1'b1;
        check("random_beats", beats_out - base, total_beats);
`ifdef STASH_STATS_EN
        check("random_pkt_cnt", pkt_cnt, committed);
        check("random_drop_cnt", drop_cnt, 0);
`endif
        repeat (5) @(posedge clk);
        #1;
        check("final_m_tvalid", m_tvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
